pipe_stage_latch: RTL and testbench
===================================

Name: pipe_stage_latch

Overview:
- Parametrised pipeline-stage register for any inter-stage boundary (fetch/decode first, then decode/execute and onward).
- Carries a PC field and an instruction field with a valid/ready handshake, flush-to-bubble and stall-hold.
- Optional 2-entry skid mode cuts the combinational ready path between stages.
- Empty or flushed slots present the NOP encoding downstream, so later stages never decode stale data.

Parameters:
- PC_W, 16, width of PC field
- INSTR_W, 16, width of instruction field
- NOP_INSTR, 16'h0800, instruction value presented when no valid entry (width INSTR_W)
- SKID, 1, 0 = single-entry latch with combinational in_ready; 1 = two-entry skid buffer with registered in_ready

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard all held entries at next edge
- in_valid  input  1  upstream presents an entry
- in_ready  output  1  block can accept an entry this cycle
- pc_in  input  PC_W  upstream PC
- instr_in  input  INSTR_W  upstream instruction
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream consumes head this cycle (0 = stall)
- pc_out  output  PC_W  head PC
- instr_out  output  INSTR_W  head instruction, NOP_INSTR when out_valid=0
- occupancy  output  2  number of held entries (0..2; max 1 when SKID=0)

Behaviour:
- Transfers: accept = in_valid & in_ready; consume = out_valid & out_ready.
- Storage:
  - Head slot: head_pc, head_instr, head_v.
  - Skid slot (SKID=1 only): skid_pc, skid_instr, skid_v.
- Reset:
  - head_v=0, skid_v=0, all data regs 0.
  - Outputs: out_valid=0, pc_out=0, instr_out=NOP_INSTR, occupancy=0, in_ready=1.
  - rst has priority over flush and all transfers.
  - Reset mid-stall discards everything; nothing is replayed.
- Output mapping (combinational from regs only):
  - out_valid=head_v; pc_out=head_pc.
  - instr_out = head_v ? head_instr : NOP_INSTR.
  - occupancy = head_v + skid_v.
- SKID=0:
  - in_ready = ~head_v | out_ready (combinational).
  - accept: head <= input, head_v<=1.
  - consume without accept: head_v<=0; data regs hold.
  - Neither: hold (stall).
  - Latency 1 cycle in->out.
- SKID=1 (states EMPTY/ONE/FULL = occupancy 0/1/2):
  - in_ready = ~skid_v (registered; no path from out_ready).
  - EMPTY: accept -> ONE, head<=input.
  - ONE, consume & accept -> ONE, head<=input.
  - ONE, consume only -> EMPTY.
  - ONE, accept only -> FULL, skid<=input.
  - ONE, neither -> hold.
  - FULL (in_ready=0): consume -> ONE, head<=skid, skid_v<=0; else hold.
  - Latency 1 cycle when EMPTY; order strictly FIFO; no entry dropped or duplicated.
- Flush:
  - Next state EMPTY (head_v<=0, skid_v<=0) regardless of out_ready.
  - An upstream accept in the same cycle is discarded; upstream sees it as transferred.
  - A downstream consume in the same cycle is still valid for downstream.
  - Data regs may hold; instr_out shows NOP_INSTR next cycle.
- Data regs update only on accept or skid->head move; held values are stable under stall.
- Widths: all data fields pass through unmodified; no arithmetic.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, instr_out=16'h0800, pc_out=0, in_ready=1, occupancy=0.
- Streaming, out_ready=1: feed PC 0x0000/0x0002/0x0004 with instr 0x1111/0x2222/0x3333 back-to-back -> each appears exactly 1 cycle later in order; occupancy stays 1.
- Stall, SKID=1:
  - out_ready=0 after first entry (0x0002, 0x2222 held), feed 0x0004/0x3333 -> occupancy=2, in_ready=0.
  - Head holds 0x0002/0x2222 across 5 stalled cycles.
  - Release out_ready -> 0x2222 then 0x3333, no loss.
- Stall, SKID=0: head valid, out_ready=0 -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> in_ready=1, head replaced next edge.
- Flush: FULL with 0x2222/0x3333, assert flush with in_valid=1 (0x4444) -> next cycle out_valid=0, instr_out=0x0800, occupancy=0; 0x4444 never appears.
- Priority: rst and flush both asserted with in_valid=1 -> reset values next cycle; then normal acceptance resumes.

Source files
------------

// File: rtl/pipe_stage_latch_if.sv
// Handshake bundle for one pipeline-stage boundary.
// slave = the stage register, master = the driving side.
interface pipe_stage_latch_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    pc_in;
  logic [INSTR_W-1:0] instr_in;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instr_out;
  logic [1:0]         occupancy;

  modport slave (
    input  in_valid, pc_in, instr_in, out_ready,
    output in_ready, out_valid, pc_out, instr_out,
           occupancy
  );

  modport master (
    output in_valid, pc_in, instr_in, out_ready,
    input  in_ready, out_valid, pc_out, instr_out,
           occupancy
  );
endinterface

// File: rtl/pipe_stage_latch.sv
// Pipeline-stage register: single latch or 2-entry skid.
// Empty slots present NOP_INSTR downstream.
module pipe_stage_latch #(
  parameter int                 PC_W      = 16,
  parameter int                 INSTR_W   = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 'h0800,
  parameter int unsigned        SKID      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  pipe_stage_latch_if.slave    bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [PC_W-1:0]    head_pc;
  logic [INSTR_W-1:0] head_instr;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic               head_v;
  logic               skid_v;
  logic               accept;
  logic               consume;
  logic               load_head;
  logic               load_skid;
  logic               move;

  assign head_v = (state_q != EMPTY);
  assign skid_v = (state_q == FULL);

  assign bus.out_valid = head_v;
  assign bus.pc_out    = head_pc;
  assign bus.instr_out = head_v ? head_instr
                                : NOP_INSTR;
  assign bus.occupancy = {1'b0, head_v}
                       + {1'b0, skid_v};

  // Skid mode decouples in_ready from out_ready.
  assign bus.in_ready = (SKID != 0) ? ~skid_v
                      : (~head_v | bus.out_ready);

  assign accept  = bus.in_valid & bus.in_ready;
  assign consume = head_v & bus.out_ready;

  // Next state and slot-load strobes; flush wins over moves.
  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    load_skid = 1'b0;
    move      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          load_head = 1'b1;
        end
      end
      ONE: begin
        if (consume && accept) begin
          load_head = 1'b1;
        end else if (consume) begin
          state_d = EMPTY;
        end else if (accept) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end
      end
      FULL: begin
        if (consume) begin
          state_d = ONE;
          move    = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  // State and data registers; data moves only on strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      head_pc    <= '0;
      head_instr <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else begin
      state_q <= state_d;
      if (load_head) begin
        head_pc    <= bus.pc_in;
        head_instr <= bus.instr_in;
      end else if (move) begin
        head_pc    <= skid_pc;
        head_instr <= skid_instr;
      end
      if (load_skid) begin
        skid_pc    <= bus.pc_in;
        skid_instr <= bus.instr_in;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Random and directed checks of both stage variants
// against a queue-based reference model.
module tb_pipe_stage_latch;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  pipe_stage_latch_if #(.PC_W(16), .INSTR_W(16)) bs();
  pipe_stage_latch_if #(.PC_W(16), .INSTR_W(16)) bl();

  pipe_stage_latch #(.SKID(1)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .bus(bs.slave)
  );
  pipe_stage_latch #(.SKID(0)) u_lat (
    .clk(clk), .rst(rst), .flush(flush), .bus(bl.slave)
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] qs[$];
  logic [31:0] ql[$];
  bit          fresh_s = 1'b1;
  bit          fresh_l = 1'b1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s obs=%h exp=%h t=%0t",
               tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic cyc(input logic r, input logic fl,
                     input logic iv,
                     input logic [15:0] pc,
                     input logic [15:0] ins,
                     input logic ordy);
    bit rdy_s, rdy_l, acc, con;
    @(negedge clk);
    rst = r;
    flush = fl;
    bs.in_valid = iv; bs.pc_in = pc;
    bs.instr_in = ins; bs.out_ready = ordy;
    bl.in_valid = iv; bl.pc_in = pc;
    bl.instr_in = ins; bl.out_ready = ordy;
    #1;
    rdy_s = (qs.size() < 2);
    chk("s_in_ready", 32'(bs.in_ready), 32'(rdy_s));
    chk("s_out_valid", 32'(bs.out_valid),
        32'(qs.size() > 0));
    chk("s_occupancy", 32'(bs.occupancy),
        32'(qs.size()));
    chk("s_instr_out", 32'(bs.instr_out),
        qs.size() ? 32'(qs[0][15:0]) : 32'h0800);
    if (qs.size())
      chk("s_pc_out", 32'(bs.pc_out),
          32'(qs[0][31:16]));
    else if (fresh_s)
      chk("s_pc_rst", 32'(bs.pc_out), 32'h0);
    rdy_l = (ql.size() == 0) || ordy;
    chk("l_in_ready", 32'(bl.in_ready), 32'(rdy_l));
    chk("l_out_valid", 32'(bl.out_valid),
        32'(ql.size() > 0));
    chk("l_occupancy", 32'(bl.occupancy),
        32'(ql.size()));
    chk("l_instr_out", 32'(bl.instr_out),
        ql.size() ? 32'(ql[0][15:0]) : 32'h0800);
    if (ql.size())
      chk("l_pc_out", 32'(bl.pc_out),
          32'(ql[0][31:16]));
    else if (fresh_l)
      chk("l_pc_rst", 32'(bl.pc_out), 32'h0);
    if (r) begin
      qs.delete(); ql.delete();
      fresh_s = 1'b1; fresh_l = 1'b1;
    end else begin
      acc = iv && rdy_s;
      con = (qs.size() > 0) && ordy;
      if (con) void'(qs.pop_front());
      if (acc) begin
        qs.push_back({pc, ins});
        fresh_s = 1'b0;
      end
      if (fl) qs.delete();
      acc = iv && rdy_l;
      con = (ql.size() > 0) && ordy;
      if (con) void'(ql.pop_front());
      if (acc) begin
        ql.push_back({pc, ins});
        fresh_l = 1'b0;
      end
      if (fl) ql.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bs.in_valid = 1'b0; bs.out_ready = 1'b0;
    bs.pc_in = '0; bs.instr_in = '0;
    bl.in_valid = 1'b0; bl.out_ready = 1'b0;
    bl.pc_in = '0; bl.instr_in = '0;
    cyc(1, 0, 0, 16'h0, 16'h0, 0);
    cyc(1, 0, 0, 16'h0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0, 16'h0, 0);
    chk("rst_instr_nop", 32'(bs.instr_out), 32'h0800);
    // streaming
    cyc(0, 0, 1, 16'h0000, 16'h1111, 1);
    cyc(0, 0, 1, 16'h0002, 16'h2222, 1);
    cyc(0, 0, 1, 16'h0004, 16'h3333, 1);
    cyc(0, 0, 0, 16'h0, 16'h0, 1);
    cyc(0, 0, 0, 16'h0, 16'h0, 1);
    // stall and release
    cyc(0, 0, 1, 16'h0002, 16'h2222, 0);
    cyc(0, 0, 1, 16'h0004, 16'h3333, 0);
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 0, 16'h0, 16'h0, 0);
    chk("stall_hold", 32'(bs.instr_out), 32'h2222);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 16'h0, 16'h0, 1);
    // latch replace on out_ready
    cyc(0, 0, 1, 16'h0010, 16'h5555, 0);
    cyc(0, 0, 1, 16'h0012, 16'h6666, 1);
    cyc(0, 0, 0, 16'h0, 16'h0, 1);
    cyc(0, 0, 0, 16'h0, 16'h0, 1);
    // flush while full
    cyc(0, 0, 1, 16'h0002, 16'h2222, 0);
    cyc(0, 0, 1, 16'h0004, 16'h3333, 0);
    cyc(0, 1, 1, 16'h0006, 16'h4444, 0);
    cyc(0, 0, 0, 16'h0, 16'h0, 1);
    chk("flush_nop", 32'(bs.instr_out), 32'h0800);
    // reset beats flush
    cyc(0, 0, 1, 16'h0008, 16'h7777, 0);
    cyc(1, 1, 1, 16'h000a, 16'h8888, 1);
    cyc(0, 0, 1, 16'h000c, 16'h9999, 1);
    cyc(0, 0, 0, 16'h0, 16'h0, 1);
    // random
    for (int i = 0; i < 2000; i++)
      cyc(($urandom_range(63) == 0),
          ($urandom_range(15) == 0),
          ($urandom_range(9) < 7),
          16'($urandom), 16'($urandom),
          ($urandom_range(9) < 6));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
